// File: rtl/vga_framebuffer_scanout_pkg.sv
// Shared definitions for the Display_VGA consumer: colour codes, VGA timing,
// operand layout and the constant-multiply helper used for cell addressing.
package vga_framebuffer_scanout_pkg;

    typedef enum logic [2:0] {
        COLOR_BLACK   = 3'b000,
        COLOR_BLUE    = 3'b001,
        COLOR_GREEN   = 3'b010,
        COLOR_CYAN    = 3'b011,
        COLOR_RED     = 3'b100,
        COLOR_MAGENTA = 3'b101,
        COLOR_YELLOW  = 3'b110,
        COLOR_WHITE   = 3'b111
    } color_e;

    localparam int unsigned VGA_CLK_DIV     = 2;
    localparam int unsigned VGA_SCALE_SHIFT = 3;
    localparam int unsigned VGA_H_VISIBLE   = 640;
    localparam int unsigned VGA_H_FP        = 16;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BP        = 48;
    localparam int unsigned VGA_V_VISIBLE   = 480;
    localparam int unsigned VGA_V_FP        = 10;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BP        = 33;

    // Display_VGA operand word: row [34:19], col [18:3], color [2:0].
    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic [2:0]  color;
    } display_vga_op_t;

    // Multiply by a constant as a sum of shifted copies; with k fixed at
    // elaboration this reduces to a small adder tree.
    function automatic logic [31:0] mul_const(input logic [31:0] x, input int unsigned k);
        logic [31:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((k >> i) & 32'd1) != 32'd0)
                acc = acc + (x << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_framebuffer_scanout_timing_gen.sv
// Pixel-enable divider, raster counters and raw sync/visible decode.
module vga_timing_gen
    import vga_framebuffer_scanout_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          pe,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          visible
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;

    assign pe = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (pe)
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            if (h == HW'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    always_comb begin
        hsync_raw = (h >= HW'(H_VISIBLE + H_FP)) && (h < HW'(H_VISIBLE + H_FP + H_SYNC));
        vsync_raw = (v >= VW'(V_VISIBLE + V_FP)) && (v < VW'(V_VISIBLE + V_FP + V_SYNC));
        visible   = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));
    end

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// Display_VGA consumer: stores pixel writes in a downscaled framebuffer and
// scans it out as VGA with a two-stage (address, RAM read) pipeline.
module vga_framebuffer_scanout
    import vga_framebuffer_scanout_pkg::*;
#(
    parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
    parameter int unsigned SCALE_SHIFT = VGA_SCALE_SHIFT,
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iWriteEnable,
    input  logic [15:0] iRow,
    input  logic [15:0] iCol,
    input  logic [2:0]  iColor,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oRed,
    output logic        oGreen,
    output logic        oBlue,
    output logic        oFrameStart
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned GRID_W  = H_VISIBLE >> SCALE_SHIFT;
    localparam int unsigned GRID_H  = V_VISIBLE >> SCALE_SHIFT;
    localparam int unsigned CELLS   = GRID_W * GRID_H;
    localparam int unsigned ADDR_W  = $clog2(CELLS);

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic              pe;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              visible;

    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;

    logic [ADDR_W-1:0] s1_addr;
    logic              s1_hsync;
    logic              s1_vsync;
    logic              s1_vis;
    logic              s1_fs;

    logic              s2_hsync;
    logic              s2_vsync;
    logic              s2_vis;
    logic              fs_pulse;

    logic [2:0]        fb [CELLS];
    logic [2:0]        rd_data;

    vga_timing_gen #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk       (Clock),
        .rst_n     (Reset),
        .h         (h),
        .v         (v),
        .pe        (pe),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .visible   (visible)
    );

    assign scan_addr = ADDR_W'(mul_const(32'(v >> SCALE_SHIFT), GRID_W) + 32'(h >> SCALE_SHIFT));
    assign wr_addr   = ADDR_W'(mul_const(32'(iRow >> SCALE_SHIFT), GRID_W) + 32'(iCol >> SCALE_SHIFT));

    // Off-screen operands would alias onto real cells once truncated, so drop them here.
    assign wr_en = iWriteEnable && Reset
                && (iRow < 16'(V_VISIBLE)) && (iCol < 16'(H_VISIBLE));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1_addr  <= '0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_vis   <= 1'b0;
            s1_fs    <= 1'b0;
        end else if (pe) begin
            s1_addr  <= visible ? scan_addr : '0;
            s1_hsync <= hsync_raw;
            s1_vsync <= vsync_raw;
            s1_vis   <= visible;
            s1_fs    <= (h == '0) && (v == '0);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s2_hsync <= 1'b0;
            s2_vsync <= 1'b0;
            s2_vis   <= 1'b0;
            fs_pulse <= 1'b0;
        end else begin
            fs_pulse <= pe && s1_fs;
            if (pe) begin
                s2_hsync <= s1_hsync;
                s2_vsync <= s1_vsync;
                s2_vis   <= s1_vis;
            end
        end
    end

    // Single block keeps read-first ordering on a same-cell write/read.
    always_ff @(posedge Clock) begin
        if (wr_en)
            fb[wr_addr] <= iColor;
        if (pe)
            rd_data <= fb[s1_addr];
    end

    assign oHSync      = ~s2_hsync;
    assign oVSync      = ~s2_vsync;
    assign oFrameStart = fs_pulse;
    assign {oRed, oGreen, oBlue} = s2_vis ? rd_data : COLOR_BLACK;

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Directed bench for vga_framebuffer_scanout on a reduced raster
// (64x46 total, 48x40 visible, 6x5 cells) with a closed-form output model.
module tb_vga_framebuffer_scanout;
    import vga_framebuffer_scanout_pkg::*;

    localparam int CLK_DIV   = 2;
    localparam int S         = 3;
    localparam int HV        = 48;
    localparam int HFP       = 4;
    localparam int HSY       = 8;
    localparam int HBP       = 4;
    localparam int VV        = 40;
    localparam int VFP       = 2;
    localparam int VSY       = 2;
    localparam int VBP       = 2;
    localparam int HT        = HV + HFP + HSY + HBP;
    localparam int VT        = VV + VFP + VSY + VBP;
    localparam int FRAME_PE  = HT * VT;
    localparam int FRAME_CLK = FRAME_PE * CLK_DIV;
    localparam int GW        = HV >> S;
    localparam int GH        = VV >> S;
    localparam int CELLS     = GW * GH;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iWriteEnable = 1'b0;
    logic [15:0] iRow = '0;
    logic [15:0] iCol = '0;
    logic [2:0]  iColor = '0;
    logic        oHSync, oVSync, oRed, oGreen, oBlue, oFrameStart;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          n = 0;
    int          win_hi = 0;
    int          hs_low = 0, vs_low = 0, fs_cnt = 0, hs_line0 = 0;
    logic [2:0]  fb_model [CELLS];
    logic [2:0]  exp_rgb = '0;
    logic        pend_we = 1'b0;
    logic [15:0] pend_row, pend_col;
    logic [2:0]  pend_color;

    always #5 Clock = ~Clock;

    vga_framebuffer_scanout #(
        .CLK_DIV     (CLK_DIV),
        .SCALE_SHIFT (S),
        .H_VISIBLE   (HV),
        .H_FP        (HFP),
        .H_SYNC      (HSY),
        .H_BP        (HBP),
        .V_VISIBLE   (VV),
        .V_FP        (VFP),
        .V_SYNC      (VSY),
        .V_BP        (VBP)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iWriteEnable (iWriteEnable),
        .iRow         (iRow),
        .iCol         (iCol),
        .iColor       (iColor),
        .oHSync       (oHSync),
        .oVSync       (oVSync),
        .oRed         (oRed),
        .oGreen       (oGreen),
        .oBlue        (oBlue),
        .oFrameStart  (oFrameStart)
    );

    function automatic logic [2:0] pat(input int c);
        return 3'((c * 5 + 1) % 8);
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    // One clock; n counts edges since reset release, outputs are sampled 1ns after the edge.
    task automatic tick(input string tag);
        logic [5:0] exp, got;
        int k, p, h, v;
        @(posedge Clock);
        #1;
        if (Reset) n++;
        got = {oHSync, oVSync, oRed, oGreen, oBlue, oFrameStart};
        k = n / CLK_DIV;
        if (!Reset || k < 2) begin
            exp = 6'b110000;
        end else begin
            p = (k - 2) % FRAME_PE;
            h = p % HT;
            v = p / HT;
            if (n % CLK_DIV == 0)
                exp_rgb = (h < HV && v < VV) ? fb_model[(v >> S) * GW + (h >> S)] : 3'b000;
            exp = {!(h >= HV + HFP && h < HV + HFP + HSY),
                   !(v >= VV + VFP && v < VV + VFP + VSY),
                   exp_rgb,
                   (n % CLK_DIV == 0) && (p == 0)};
        end
        check_vec(tag, 32'(got), 32'(exp));
        if (Reset && n >= 4 && n < win_hi) begin
            if (!oHSync) hs_low++;
            if (!oVSync) vs_low++;
            if (oFrameStart) fs_cnt++;
            if (!oHSync && n < 4 + HT * CLK_DIV) hs_line0++;
        end
        if (pend_we && Reset && pend_row < VV && pend_col < HV)
            fb_model[(pend_row >> S) * GW + (pend_col >> S)] = pend_color;
        pend_we = 1'b0;
        iWriteEnable = 1'b0;
    endtask

    task automatic wr(input int row, input int col, input logic [2:0] color, input string tag);
        iWriteEnable = 1'b1;
        iRow = 16'(row);
        iCol = 16'(col);
        iColor = color;
        pend_we = 1'b1;
        pend_row = 16'(row);
        pend_col = 16'(col);
        pend_color = color;
        tick(tag);
    endtask

    task automatic goto_n(input int target, input string tag);
        int guard;
        guard = 0;
        while (n < target && guard < 200000) begin
            tick(tag);
            guard++;
        end
        if (n != target) check_vec("goto_reach", 32'(n), 32'(target));
    endtask

    task automatic goto_pos(input int f, input int h, input int v, input string tag);
        goto_n(CLK_DIV * (f * FRAME_PE + v * HT + h + 2), tag);
    endtask

    function automatic logic [31:0] rgb();
        return 32'({oRed, oGreen, oBlue});
    endfunction

    initial begin
        int nt;
        for (int c = 0; c < CELLS; c++) fb_model[c] = '0;

        repeat (3) tick("reset_hold");
        Reset = 1'b1;
        n = 0;
        win_hi = 4 + FRAME_CLK;

        for (int c = 0; c < CELLS; c++)
            wr((c / GW) << S, (c % GW) << S, COLOR_MAGENTA, "fill_magenta");

        goto_pos(1, 0, 0, "frame0");
        check_vec("hsync_low_line0", 32'(hs_line0), 32'(HSY * CLK_DIV));
        check_vec("hsync_low_frame", 32'(hs_low), 32'(VT * HSY * CLK_DIV));
        check_vec("vsync_low_frame", 32'(vs_low), 32'(VSY * HT * CLK_DIV));
        check_vec("framestart_count", 32'(fs_cnt), 32'd1);
        win_hi = 0;

        wr(13, 20, COLOR_GREEN, "single_write");
        goto_pos(1, 15, 8, "frame1");
        check_vec("left_neighbour", rgb(), 32'(COLOR_MAGENTA));
        goto_pos(1, 16, 8, "frame1");
        check_vec("single_px_tl", rgb(), 32'(COLOR_GREEN));
        goto_pos(1, 24, 8, "frame1");
        check_vec("right_neighbour", rgb(), 32'(COLOR_MAGENTA));
        goto_pos(1, 23, 15, "frame1");
        check_vec("single_px_br", rgb(), 32'(COLOR_GREEN));

        for (int c = 0; c < CELLS; c++)
            wr((c / GW) << S, (c % GW) << S, pat(c), "fill_pattern");
        wr(40, 47, COLOR_RED, "oor_row");
        wr(3, 48, COLOR_RED, "oor_col");
        wr(0, 100, COLOR_RED, "oor_col_far");
        wr(39, 47, COLOR_WHITE, "edge_write");

        goto_pos(2, 24, 0, "frame2");
        check_vec("oor_alias_cell3", rgb(), 32'(pat(3)));
        goto_pos(2, 48, 0, "frame2");
        check_vec("hblank_black", rgb(), 32'd0);
        goto_pos(2, 0, 8, "frame2");
        check_vec("oor_alias_cell6", rgb(), 32'(pat(6)));
        goto_pos(2, 0, 16, "frame2");
        check_vec("oor_alias_cell12", rgb(), 32'(pat(12)));
        goto_pos(2, 47, 39, "frame2");
        check_vec("last_cell", rgb(), 32'(COLOR_WHITE));
        goto_pos(2, 0, 40, "frame2");
        check_vec("vblank_black", rgb(), 32'd0);

        nt = CLK_DIV * (3 * FRAME_PE + 16 * HT + 24 + 2);
        goto_n(nt - 1, "frame3");
        wr(16, 24, COLOR_BLUE, "collision");
        check_vec("collide_old", rgb(), 32'(pat(15)));
        goto_pos(3, 25, 16, "frame3");
        check_vec("collide_next_px", rgb(), 32'(COLOR_BLUE));
        goto_pos(4, 24, 16, "frame4");
        check_vec("collide_next_frame", rgb(), 32'(COLOR_BLUE));

        goto_pos(4, 20, 20, "frame4");
        check_vec("pre_reset_px", rgb(), 32'(pat(14)));
        Reset = 1'b0;
        #1;
        check_vec("reset_async", 32'({oHSync, oVSync, oRed, oGreen, oBlue, oFrameStart}), 32'(6'b110000));
        n = 0;
        wr(0, 0, COLOR_RED, "write_in_reset");
        repeat (2) tick("reset_hold2");
        Reset = 1'b1;
        repeat (3) tick("restart");
        check_vec("fs_early", 32'(oFrameStart), 32'd0);
        tick("restart");
        check_vec("fs_after_reset", 32'(oFrameStart), 32'd1);
        check_vec("cell0_kept", rgb(), 32'(pat(0)));
        tick("restart");
        check_vec("fs_one_clock", 32'(oFrameStart), 32'd0);
        goto_pos(1, 0, 0, "post_reset_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, n=%0d", n);
        $fatal(1);
    end

endmodule

// File: doc/vga_framebuffer_scanout.md
Name: vga_framebuffer_scanout

Overview:
- Consumer side of the `Display_VGA` instruction.
- The CPU core executes `Display_VGA` with color, row and column operands, and presents them as a single-cycle pixel write to this block.
- The block stores writes in a downscaled on-chip framebuffer and continuously scans it out as 640x480@60 Hz VGA, with active-low syncs and 3-bit RGB.
- Sits between the CPU execute stage and the board VGA connector.

Parameters:
- CLK_DIV, 2, system clocks per pixel; a 50 MHz Clock gives a 25 MHz pixel rate.
- SCALE_SHIFT, 3, log2 of screen pixels per framebuffer cell edge; the default gives an 80x60-cell grid.
- H_VISIBLE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixels (total 800).
- V_VISIBLE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines (total 525).

Ports:
- Clock  in  1  system clock; all state is on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iWriteEnable  in  1  single-cycle pixel write strobe from execute.
- iRow  in  16  screen row in pixels (operand of `Display_VGA`).
- iCol  in  16  screen column in pixels.
- iColor  in  3  {R,G,B}, using the `COLOR_*` encoding.
- oHSync  out  1  horizontal sync, active low.
- oVSync  out  1  vertical sync, active low.
- oRed, oGreen, oBlue  out  1 each  pixel color; forced to 0 outside the visible area.
- oFrameStart  out  1  one-Clock pulse when the output raster reaches (h=0, v=0).

Behaviour:
- **Reset** (Reset=0, asynchronous):
  - Pixel-enable divider, h counter and v counter go to 0.
  - oHSync=1, oVSync=1, RGB=0, oFrameStart=0.
  - Framebuffer contents are NOT cleared; they are undefined after power-up.
  - A reset mid-frame restarts the raster at (0,0) on the first enable after release.
- **Pixel enable**: pe is asserted one Clock in every CLK_DIV. The first pe occurs CLK_DIV-1 Clocks after Reset deasserts. Counters advance only on pe.
- **Counters**:
  - h runs 0..799 and wraps to 0.
  - v increments when h wraps, and wraps 524 to 0.
- **Sync decode**:
  - hsync is active for h in [656,751].
  - vsync is active for v in [490,491].
  - Visible region is h<640 and v<480.
- **Pipeline**:
  - Stage 1 registers the cell address = (v>>S)*(640>>S) + (h>>S).
  - Stage 2 is the synchronous RAM read.
  - Sync, visible and frame-start decodes are delayed by the same 2 pe ticks, so all outputs refer to the same raster position.
  - Outputs are registered and change only on pe.
- **oFrameStart**: high for exactly one Clock, on the pe at which the output raster position is (0,0).
- **Write path**:
  - When iWriteEnable=1, cell (iRow>>S)*(640>>S) + (iCol>>S) is written with iColor on the same Clock, independent of pe.
  - A write with iRow≥480 or iCol≥640 is silently ignored.
  - Writes during reset are ignored.
- **Collision**: a write and a scan read to the same cell in the same Clock returns the OLD value to scanout (read-first); the new value appears on the next frame.
- **Arithmetic**:
  - Address width is ceil(log2(cells)), 13 bits at the default.
  - The multiply by the grid width must be a constant multiply (shift/add); no generic multiplier.
- **Throughput**: the write port accepts one write every Clock with no back-pressure; there is no busy output.

Decomposition:
- Shared definitions file (existing Definitions include):
  - the `COLOR_*` 3-bit codes, including COLOR_BLACK=3'b000;
  - the VGA timing constants;
  - the `Display_VGA` operand field positions.
- One sub-module, vga_timing_gen: divider, h/v counters and sync/visible decode. Outputs h, v, pe, hsync_raw, vsync_raw, visible.
- The framebuffer RAM is inferred inline as a simple dual-port (one write, one read) block RAM.

Test Plan:
- **Timing:** hold Reset low, release, run 840000 Clocks. Require:
  - oHSync low for exactly 192 Clocks per 1600-Clock line;
  - oVSync low for exactly 3200 Clocks per frame;
  - oFrameStart pulses exactly once per 840000 Clocks.
- **Single write:** write iRow=141, iCol=336, iColor=`COLOR_GREEN` (cell 17,42).
  - Next frame: screen pixels rows 136..143, cols 336..343 show G=1, R=0, B=0.
  - Neighbouring cell (17,43) keeps its prior value.
- **Blanking:** fill every cell with `COLOR_MAGENTA`. RGB must be 0 whenever h≥640 or v≥480, and magenta everywhere visible.
- **Out of range:** write iRow=480, iCol=100 and iRow=10, iCol=640, each with `COLOR_RED`. Framebuffer is unchanged (checked by full-frame compare).
- **Collision:** write `COLOR_BLUE` to the cell being read in that exact Clock. Current frame shows the old color; the following frame shows blue.
- **Mid-frame reset:** assert Reset at h=300, v=200.
  - Outputs immediately read oHSync=1, oVSync=1, RGB=0.
  - After release, oFrameStart fires once the output raster reaches (0,0) (2 pe ticks after the first pe).
  - Previously written cells are still displayed.
